// File: rtl/unified_mem_arbiter_if.sv
// Bundle of fetch, data and memory-side handshake signals for unified_mem_arbiter.
// The arbiter uses the slave view; the requesters and memory use the master view.
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] rdata;
   logic              resp_err;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      output if_gnt, if_rvalid, d_gnt, d_rvalid, rdata, resp_err,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      input  if_gnt, if_rvalid, d_gnt, d_rvalid, rdata, resp_err,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module unified_mem_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   unified_mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              owner_data_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              if_gnt_q;
   logic              d_gnt_q;
   logic              if_rvalid_q;
   logic              d_rvalid_q;
   logic              mem_req_q;
   logic              win_data;

`ifdef ARB_ROUND_ROBIN_EN
   logic              last_data_q;

   // Under contention the side that did not win last time gets the memory.
   always_comb begin
      win_data = bus.d_req && (!bus.if_req || !last_data_q);
   end
`else
   always_comb begin
      win_data = bus.d_req;
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         owner_data_q <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         if_gnt_q     <= 1'b0;
         d_gnt_q      <= 1'b0;
         if_rvalid_q  <= 1'b0;
         d_rvalid_q   <= 1'b0;
         mem_req_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_data_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.if_req || bus.d_req) begin
                  owner_data_q <= win_data;
                  we_q         <= win_data && bus.d_we;
                  addr_q       <= win_data ? bus.d_addr : bus.if_addr;
                  wdata_q      <= win_data ? bus.d_wdata : '0;
                  if_gnt_q     <= !win_data;
                  d_gnt_q      <= win_data;
                  mem_req_q    <= 1'b1;
                  cnt_q        <= '0;
                  state_q      <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                  if (bus.if_req && bus.d_req) begin
                     last_data_q <= win_data;
                  end
`endif
               end
            end
            BUSY: begin
               if_gnt_q <= 1'b0;
               d_gnt_q  <= 1'b0;
               cnt_q    <= cnt_q + CNT_W'(1);
               // An ack on the final allowed cycle still counts as success.
               if (bus.mem_ack || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                  rdata_q     <= (bus.mem_ack && !we_q) ? bus.mem_rdata : '0;
                  err_q       <= !bus.mem_ack;
                  mem_req_q   <= 1'b0;
                  if_rvalid_q <= !owner_data_q;
                  d_rvalid_q  <= owner_data_q;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if_rvalid_q <= 1'b0;
               d_rvalid_q  <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.if_gnt    = if_gnt_q;
   assign bus.d_gnt     = d_gnt_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.rdata     = rdata_q;
   assign bus.resp_err  = err_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
endmodule
